tlb_responder: RTL and testbench



---
 rtl/tlb_responder.sv | 181 ++++++++++++++++++
 tb/tb_tlb_responder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_responder.sv
// Fully-associative TLB responder: READ looks up a virtual page number, WRITE fills/updates an entry.
// Latency: 1 cycle from request acceptance to resp_valid; back-to-back 1 request/cycle with resp_ready=1.
// Backpressure: req_ready drops while flush is high or a held response is not consumed (resp_valid && !resp_ready).
// Optional hit/miss statistics counters are built when TLB_STATS_EN is defined.

`ifndef VIRTUAL_ADDR_WIDTH
`define VIRTUAL_ADDR_WIDTH 32
`endif
`ifndef PHYSICAL_ADDR_WIDTH
`define PHYSICAL_ADDR_WIDTH 32
`endif
`ifndef PAGE_SIZE
`define PAGE_SIZE 4096
`endif

module tlb_responder #(
    parameter int KEY_WIDTH   = `VIRTUAL_ADDR_WIDTH - $clog2(`PAGE_SIZE),
    parameter int VALUE_WIDTH = `PHYSICAL_ADDR_WIDTH - $clog2(`PAGE_SIZE),
    parameter int ENTRIES     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_op,
    input  logic [KEY_WIDTH-1:0]   req_key,
    input  logic [VALUE_WIDTH-1:0] req_value,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic                   resp_hit,
    output logic [VALUE_WIDTH-1:0] resp_value,
    input  logic                   flush
`ifdef TLB_STATS_EN
    ,
    output logic [31:0]            hit_count,
    output logic [31:0]            miss_count
`endif
);

    localparam int   IDX_W    = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam logic OP_WRITE = 1'b1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    // Entry storage: valid bits are reset, key/value payload is not.
    logic [ENTRIES-1:0]     valid_q, valid_d;
    logic [KEY_WIDTH-1:0]   key_q [ENTRIES];
    logic [VALUE_WIDTH-1:0] val_q [ENTRIES];

    // FIFO replacement pointer.
    logic [IDX_W-1:0]       repl_ptr_q, repl_ptr_d;

    // Registered response stage.
    logic                   resp_valid_q, resp_valid_d;
    logic                   resp_hit_q, resp_hit_d;
    logic [VALUE_WIDTH-1:0] resp_value_q, resp_value_d;

    // Lookup results and array write control.
    logic                   accept;
    logic                   match_found;
    logic [IDX_W-1:0]       match_idx;
    logic [VALUE_WIDTH-1:0] match_value;
    logic                   wr_en;
    logic [IDX_W-1:0]       wr_idx;

    // A new request may enter only when the response slot is free or draining
    // this cycle; flush blocks acceptance so an array update never races it.
    assign req_ready = !flush && (!resp_valid_q || resp_ready);
    assign accept    = req_valid && req_ready;

    // Associative compare of the request key against every valid entry.
    // Duplicate valid keys cannot exist, so at most one entry matches.
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && (key_q[i] == req_key)) begin
                match_found = 1'b1;
                match_idx   = IDX_W'(i);
            end
        end
    end

    assign match_value = val_q[match_idx];

    // Next-state for valid bits, replacement pointer and the response stage.
    always_comb begin
        valid_d      = valid_q;
        repl_ptr_d   = repl_ptr_q;
        resp_valid_d = resp_valid_q;
        resp_hit_d   = resp_hit_q;
        resp_value_d = resp_value_q;
        wr_en        = 1'b0;
        wr_idx       = match_idx;

        if (flush) begin
            valid_d    = '0;
            repl_ptr_d = '0;
        end

        if (accept) begin
            resp_valid_d = 1'b1;
            resp_hit_d   = match_found;
            if (req_op == OP_WRITE) begin
                wr_en        = 1'b1;
                resp_value_d = req_value;
                if (!match_found) begin
                    // Miss: the FIFO victim is overwritten even if it is valid.
                    wr_idx           = repl_ptr_q;
                    valid_d[repl_ptr_q] = 1'b1;
                    repl_ptr_d       = (repl_ptr_q == LAST_IDX) ? '0 : repl_ptr_q + 1'b1;
                end
            end else begin
                resp_value_d = match_found ? match_value : '0;
            end
        end else if (resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    // Control state: valid bits, replacement pointer and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= '0;
            repl_ptr_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_value_q <= '0;
        end else begin
            valid_q      <= valid_d;
            repl_ptr_q   <= repl_ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_hit_q   <= resp_hit_d;
            resp_value_q <= resp_value_d;
        end
    end

    // Key/value payload write; no reset needed since valid bits gate every use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            key_q[wr_idx] <= req_key;
            val_q[wr_idx] <= req_value;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_hit   = resp_hit_q;
    assign resp_value = resp_value_q;

`ifdef TLB_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    // Saturating per-READ hit/miss counters; flush leaves them untouched.
    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (accept && (req_op != OP_WRITE)) begin
            if (match_found) begin
                if (hit_count_q != 32'hFFFF_FFFF) hit_count_d = hit_count_q + 32'd1;
            end else begin
                if (miss_count_q != 32'hFFFF_FFFF) miss_count_d = miss_count_q + 32'd1;
            end
        end
    end

    // Statistics registers, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_tlb_responder.sv
// Directed scoreboard bench for tlb_responder (8 entries, 20-bit keys/values).
// Inputs are driven 2 time units after each rising edge; outputs are sampled on the falling edge.
// A monitor pops the expected-response queue on every resp_valid && resp_ready cycle.

module tb_tlb_responder;

    localparam int KW = 20;
    localparam int VW = 20;
    localparam int N  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_op = 1'b0;
    logic [KW-1:0] req_key = '0;
    logic [VW-1:0] req_value = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic          resp_hit;
    logic [VW-1:0] resp_value;
    logic          flush = 1'b0;
`ifdef TLB_STATS_EN
    logic [31:0]   hit_count;
    logic [31:0]   miss_count;
`endif

    always #5 clk = ~clk;

    tlb_responder #(
        .KEY_WIDTH   (KW),
        .VALUE_WIDTH (VW),
        .ENTRIES     (N)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_key    (req_key),
        .req_value  (req_value),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_hit   (resp_hit),
        .resp_value (resp_value),
        .flush      (flush)
`ifdef TLB_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    typedef struct packed {
        logic          hit;
        logic [VW-1:0] value;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   exp_hits = 0;
    int   exp_misses = 0;
    int   last_wait = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: compare each consumed response against the queue head.
    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got hit=%0d value=0x%0h, expected no response (t=%0t)",
                         resp_hit, resp_value, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_hit", 32'(resp_hit), 32'(mon_e.hit));
                check("resp_value", 32'(resp_value), 32'(mon_e.value));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Present one request and push its expected response once it is accepted.
    // Entered and left at 2 time units after a rising edge.
    task automatic issue(input logic op, input logic [KW-1:0] key, input logic [VW-1:0] val,
                         input logic ehit, input logic [VW-1:0] evalue);
        exp_t e;
        bit   done = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_key   = key;
        req_value = val;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (req_ready) begin
                e.hit   = ehit;
                e.value = evalue;
                exp_q.push_back(e);
                if (op == 1'b0) begin
                    if (ehit) exp_hits++;
                    else      exp_misses++;
                end
                last_wait = c;
                done = 1;
            end
            step();
        end
        req_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: key 0x%0h not accepted, expected acceptance within 40 cycles", key);
        end
    endtask

    task automatic rd(input logic [KW-1:0] key, input logic ehit, input logic [VW-1:0] evalue);
        issue(1'b0, key, '0, ehit, evalue);
    endtask

    task automatic wr(input logic [KW-1:0] key, input logic [VW-1:0] val, input logic ehit);
        issue(1'b1, key, val, ehit, val);
    endtask

    // Let every outstanding response drain.
    task automatic drain();
        bit done = 0;
        resp_ready = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            if (exp_q.size() == 0 && !resp_valid) done = 1;
            else step();
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic flush_pulse();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exhausted, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("reset_resp_valid", 32'(resp_valid), 32'd0);
        check("reset_resp_hit", 32'(resp_hit), 32'd0);
        check("reset_resp_value", 32'(resp_value), 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        step();

        // Cold lookup misses, fill, then hit
        rd(20'h12, 1'b0, 20'h0);
        wr(20'h12, 20'h345, 1'b0);
        rd(20'h12, 1'b1, 20'h345);

        // Overwrite an existing entry: hit, pointer stays at slot 1
        wr(20'h12, 20'h777, 1'b1);
        rd(20'h12, 1'b1, 20'h777);
        drain();
        check("ptr_after_update", 32'(dut.repl_ptr_q), 32'd1);

        // Seven new keys fill slots 1..7; the eighth wraps to slot 0 and evicts 0x12
        for (int k = 16'h13; k <= 16'h19; k++) wr(KW'(k), VW'(16'h500 + k), 1'b0);
        wr(20'h1A, 20'h51A, 1'b0);
        rd(20'h12, 1'b0, 20'h0);
        rd(20'h13, 1'b1, 20'h513);
        rd(20'h1A, 1'b1, 20'h51A);

        // Keys 0..8 into a flushed table: key 0 is evicted, pointer ends at 1
        drain();
        flush_pulse();
        for (int k = 0; k <= 8; k++) wr(KW'(k), VW'(16'h100 + k), 1'b0);
        rd(20'h0, 1'b0, 20'h0);
        for (int k = 1; k <= 8; k++) rd(KW'(k), 1'b1, VW'(16'h100 + k));
        drain();
        check("ptr_after_wrap", 32'(dut.repl_ptr_q), 32'd1);
        wr(20'h20, 20'h120, 1'b0);
        rd(20'h1, 1'b0, 20'h0);
        rd(20'h2, 1'b1, 20'h102);

        // Backpressure: response held for 3 cycles with a second request waiting
        drain();
        resp_ready = 1'b0;
        rd(20'h2, 1'b1, 20'h102);
        req_valid = 1'b1;
        req_op    = 1'b0;
        req_key   = 20'h3;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_resp_valid", 32'(resp_valid), 32'd1);
            check("bp_resp_hit", 32'(resp_hit), 32'd1);
            check("bp_resp_value", 32'(resp_value), 32'h102);
            step();
        end
        check("bp_queue_depth", 32'(exp_q.size()), 32'd1);
        resp_ready = 1'b1;
        rd(20'h3, 1'b1, 20'h103);
        check("bp_release_wait", 32'(last_wait), 32'd0);

        // Flush while a response is pending
        drain();
        flush_pulse();
        wr(20'h30, 20'h630, 1'b0);
        wr(20'h31, 20'h631, 1'b0);
        wr(20'h32, 20'h632, 1'b0);
        drain();
        resp_ready = 1'b0;
        rd(20'h31, 1'b1, 20'h631);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_op    = 1'b0;
        req_key   = 20'h30;
        @(negedge clk);
        check("flush_req_ready", 32'(req_ready), 32'd0);
        check("flush_resp_valid", 32'(resp_valid), 32'd1);
        step();
        flush     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("post_flush_resp_valid", 32'(resp_valid), 32'd1);
        check("post_flush_resp_value", 32'(resp_value), 32'h631);
        check("post_flush_ptr", 32'(dut.repl_ptr_q), 32'd0);
        step();
        drain();
        rd(20'h30, 1'b0, 20'h0);
        rd(20'h31, 1'b0, 20'h0);
        rd(20'h32, 1'b0, 20'h0);
        wr(20'h40, 20'h640, 1'b0);
        drain();
        check("ptr_after_flush_write", 32'(dut.repl_ptr_q), 32'd1);
`ifdef TLB_STATS_EN
        check("hit_count", hit_count, 32'(exp_hits));
        check("miss_count", miss_count, 32'(exp_misses));
`endif

        // Reset with a pending response discards it and empties the table
        resp_ready = 1'b0;
        rd(20'h40, 1'b1, 20'h640);
        #1 rst_n = 1'b0;
        #1;
        check("midreset_resp_valid", 32'(resp_valid), 32'd0);
        exp_q.delete();
        exp_hits   = 0;
        exp_misses = 0;
        step();
        rst_n      = 1'b1;
        resp_ready = 1'b1;
        step();
        rd(20'h40, 1'b0, 20'h0);
        drain();
`ifdef TLB_STATS_EN
        check("hit_count_after_reset", hit_count, 32'(exp_hits));
        check("miss_count_after_reset", miss_count, 32'(exp_misses));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
